// File: rtl/com_ram_pkg.sv
// Shared helpers for the com_* RAM shells.
// Width functions for lanes and addresses plus the system word width.
package com_ram_pkg;

  localparam int COM_SYS_W = 32;

  function automatic int lane_w(int data_w, int strb_w);
    return (strb_w > 0) ? data_w / strb_w : data_w;
  endfunction

  function automatic int addr_w(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/com_tpram_dff_lane.sv
// One write lane of the flop RAM: storage column plus write decode.
// Ports: clk, rst, we, wr_addr, wr_data, rd_addr -> rd_word (comb).
module com_tpram_dff_lane #(
  parameter int LANE_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LANE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LANE_W-1:0] rd_word
);

  logic [LANE_W-1:0] col [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) col[w] <= '0;
    end else if (we) begin
      for (int w = 0; w < DEPTH; w++)
        if (wr_addr == ADDR_W'(w)) col[w] <= wr_data;
    end
  end

  // Address compare mux: an address matching no word reads as 0.
  always_comb begin
    rd_word = '0;
    for (int w = 0; w < DEPTH; w++)
      if (rd_addr == ADDR_W'(w)) rd_word = col[w];
  end

endmodule

// File: rtl/com_tpram_dff.sv
// Flop-based 1W/1R RAM, one clock, per-lane strobes, 1-cycle read.
// Ports: clk, rst, wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data.
module com_tpram_dff
  import com_ram_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  parameter  int STRB_W = 1,
  localparam int ADDR_W = addr_w(DEPTH),
  localparam int LANE_W = lane_w(DATA_W, STRB_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STRB_W-1:0] wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  if (STRB_W < 1 || STRB_W > DATA_W ||
      (DATA_W % STRB_W) != 0) begin : g_bad_cfg
    $fatal(1, "com_tpram_dff: bad DATA_W/STRB_W");
  end

  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;

  assign wr_ok = 32'(wr_addr) < DEPTH;
  assign rd_ok = 32'(rd_addr) < DEPTH;

  for (genvar i = 0; i < STRB_W; i++) begin : g_lane
    com_tpram_dff_lane #(
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en[i] & wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data[i*LANE_W +: LANE_W]),
      .rd_addr (rd_addr),
      .rd_word (rd_word[i*LANE_W +: LANE_W])
    );
  end

  // Storage updates on the same edge, so this samples pre-write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_ok ? rd_word : '0;
  end

endmodule

// File: tb/tb_com_tpram_dff.sv
// Directed and randomised checks of com_tpram_dff in four configurations.
// A: 32x64 S1, B: 30x64 S2, C: 32x40 S1, R: 32x33 S4 vs a model.
module tb_com_tpram_dff;

  logic        clk = 0;
  logic        rst = 1;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [5:0]  rd_addr = '0;
  logic        wr_en_a = 0, wr_en_c = 0;
  logic [1:0]  wr_en_b = '0;
  logic [3:0]  wr_en_r = '0;
  logic        rd_en_a = 0, rd_en_b = 0;
  logic        rd_en_c = 0, rd_en_r = 0;
  logic [31:0] rd_a, rd_c, rd_r;
  logic [29:0] rd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  com_tpram_dff #(.DATA_W(32), .DEPTH(64), .STRB_W(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en_a), .rd_addr(rd_addr),
    .rd_data(rd_a));

  com_tpram_dff #(.DATA_W(30), .DEPTH(64), .STRB_W(2)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr),
    .wr_data(wr_data[29:0]), .rd_en(rd_en_b), .rd_addr(rd_addr),
    .rd_data(rd_b));

  com_tpram_dff #(.DATA_W(32), .DEPTH(40), .STRB_W(1)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en_c), .rd_addr(rd_addr),
    .rd_data(rd_c));

  com_tpram_dff #(.DATA_W(32), .DEPTH(33), .STRB_W(4)) u_r (
    .clk(clk), .rst(rst), .wr_en(wr_en_r), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en_r), .rd_addr(rd_addr),
    .rd_data(rd_r));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m [33];
  logic [31:0] exp_r;
  int          wa, ra;

  initial begin
    #3;
    check("rst_a", rd_a, 32'h0);
    check("rst_b", {2'b0, rd_b}, 32'h0);
    check("rst_c", rd_c, 32'h0);
    check("rst_r", rd_r, 32'h0);
    step();
    rst = 0;

    // write / readback, 1-cycle latency
    wr_en_a = 1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_en_a = 0; rd_en_a = 1; rd_addr = 6'd5;
    check("rb_pre", rd_a, 32'h0);
    step();
    check("rb_5", rd_a, 32'hDEADBEEF);
    rd_en_a = 0;

    // collision: read-first
    wr_en_a = 1; wr_addr = 6'd7; wr_data = 32'h11;
    step();
    rd_en_a = 1; rd_addr = 6'd7; wr_data = 32'h22;
    step();
    check("coll_old", rd_a, 32'h11);
    wr_en_a = 0;
    step();
    check("coll_new", rd_a, 32'h22);

    // mid-run async reset; ports ignored while high
    rst = 1;
    #2;
    check("rst_async", rd_a, 32'h0);
    wr_en_a = 1; wr_addr = 6'd0; wr_data = 32'hFFFFFFFF;
    rd_addr = 6'd7;
    step();
    check("rst_hold", rd_a, 32'h0);
    rst = 0; wr_en_a = 0;
    rd_addr = 6'd5;
    step();
    check("rst_mem5", rd_a, 32'h0);
    rd_addr = 6'd0;
    step();
    check("rst_mem0", rd_a, 32'h0);
    rd_addr = 6'd63;
    step();
    check("rst_mem63", rd_a, 32'h0);
    rd_en_a = 0;

    // partial lane writes, LANE_W=15
    wr_en_b = 2'b11; wr_addr = 6'd3; wr_data = 32'h3FFFFFFF;
    step();
    wr_en_b = 2'b01; wr_data = 32'h0;
    step();
    wr_en_b = 2'b00; rd_en_b = 1; rd_addr = 6'd3;
    step();
    check("part_lo", {2'b0, rd_b}, 32'h3FFF8000);
    rd_en_b = 0; wr_en_b = 2'b10;
    step();
    wr_en_b = 2'b00; rd_en_b = 1;
    step();
    check("part_hi", {2'b0, rd_b}, 32'h0);
    rd_en_b = 0;

    // hold and out of range, DEPTH=40
    wr_en_c = 1; wr_addr = 6'd0; wr_data = 32'h0000A5A5;
    step();
    wr_addr = 6'd39; wr_data = 32'hCAFE0039;
    step();
    wr_en_c = 0; rd_en_c = 1; rd_addr = 6'd39;
    step();
    check("c_rd39", rd_c, 32'hCAFE0039);
    rd_en_c = 0;
    for (int k = 0; k < 3; k++) begin
      rd_addr = 6'(k + 1);
      step();
      check("c_hold", rd_c, 32'hCAFE0039);
    end
    wr_en_c = 1; wr_addr = 6'd45; wr_data = 32'hFFFFFFFF;
    step();
    wr_en_c = 0; rd_en_c = 1; rd_addr = 6'd45;
    step();
    check("c_oor45", rd_c, 32'h0);
    for (int k = 0; k < 40; k++) begin
      rd_addr = 6'(k);
      step();
      check($sformatf("c_mem%0d", k), rd_c,
            (k == 0)  ? 32'h0000A5A5 :
            (k == 39) ? 32'hCAFE0039 : 32'h0);
    end
    rd_en_c = 0;

    // random regression against a model, DEPTH=33, 4 lanes
    for (int i = 0; i < 33; i++) m[i] = '0;
    exp_r = '0;
    for (int n = 0; n < 3000; n++) begin
      wa = $urandom_range(0, 40);
      ra = $urandom_range(0, 40);
      wr_en_r = 4'($urandom_range(0, 15));
      rd_en_r = 1'($urandom_range(0, 1));
      wr_addr = 6'(wa);
      rd_addr = 6'(ra);
      wr_data = $urandom;
      if (rd_en_r) exp_r = (ra < 33) ? m[ra] : 32'h0;
      if (wa < 33)
        for (int b = 0; b < 4; b++)
          if (wr_en_r[b]) m[wa][b*8 +: 8] = wr_data[b*8 +: 8];
      step();
      check("rand", rd_r, exp_r);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
